// File: rtl/acumulador_cla_16_if.sv
// Handshake bundle for acumulador_cla_16.
// master drives operands/start, slave is the accumulator.
interface acumulador_cla_16_if #(
  parameter int N  = 16,
  parameter int CW = 5
);
  logic          start;
  logic [CW-1:0] n_ops;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_ovf;
  logic          busy;

  modport master (
    output start, n_ops, in_valid,
    output in_data, out_ready,
    input  in_ready, out_valid,
    input  out_sum, out_ovf, busy
  );

  modport slave (
    input  start, n_ops, in_valid,
    input  in_data, out_ready,
    output in_ready, out_valid,
    output out_sum, out_ovf, busy
  );
endinterface

// File: rtl/acumulador_cla_16.sv
// Handshaked accumulator over a 16-bit carry-lookahead adder.
// Optional macro ACUM_SATURATE_EN: clamp acc to 16'hFFFF on carry.
module CLA_16bits (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = A & B;
  assign p = A ^ B;

  // Two-level lookahead: group G/P, then carries into each bit
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1]
               & g[4*k]);
    end
    gc[0] = Cin;
    gc[1] = gg[0] | (gp[0] & Cin);
    gc[2] = gg[1] | (gp[1] & gg[0])
          | (gp[1] & gp[0] & Cin);
    gc[3] = gg[2] | (gp[2] & gg[1])
          | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & Cin);
    gc[4] = gg[3] | (gp[3] & gg[2])
          | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & gc[k]);
    end
  end

  assign S    = p ^ c;
  assign Cout = gc[4];
endmodule

module acumulador_cla_16 #(
  parameter int N       = 16,
  parameter int MAX_OPS = 16,
  parameter int CW      = $clog2(MAX_OPS + 1)
) (
  input logic               clk,
  input logic               rst_n,
  acumulador_cla_16_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ACC, DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] rem_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [N-1:0]  out_sum_q;
  logic          out_ovf_q;
  logic          busy_q;

  logic [N-1:0]  cla_s;
  logic          cla_co;
  logic [CW-1:0] n_clamp;
  logic          accept;

  CLA_16bits u_cla (
    .A    (acc_q),
    .B    (bus.in_data),
    .Cin  (1'b0),
    .S    (cla_s),
    .Cout (cla_co)
  );

  // Next acc/ovf for an accepted operand, clamped count
  always_comb begin
    ovf_d = ovf_q | cla_co;
`ifdef ACUM_SATURATE_EN
    acc_d = ovf_d ? '1 : cla_s;
`else
    acc_d = cla_s;
`endif
    n_clamp = (bus.n_ops > CW'(MAX_OPS))
            ? CW'(MAX_OPS) : bus.n_ops;
    accept  = in_ready_q & bus.in_valid;
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (n_clamp == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_sum_q   <= '0;
              out_ovf_q   <= 1'b0;
            end else begin
              state_q    <= ACC;
              rem_q      <= n_clamp;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == CW'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_d;
              out_ovf_q   <= ovf_d;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_acumulador_cla_16.sv
// Bench for acumulador_cla_16: directed cases plus random runs.
// Expected results come from plain integer sums of the operands.
module tb_acumulador_cla_16;
  localparam int N       = 16;
  localparam int MAX_OPS = 16;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acumulador_cla_16_if #(.N(N), .CW(CW)) bus ();

  acumulador_cla_16 #(
    .N(N), .MAX_OPS(MAX_OPS), .CW(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] ops[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Result = {ovf, sum} from the true mathematical total
  function automatic logic [16:0] model(input int n);
    longint total = 0;
    logic   ov;
    logic [15:0] s;
    for (int i = 0; i < n; i++) total += ops[i];
    ov = (total > 65535);
    s  = total[15:0];
`ifdef ACUM_SATURATE_EN
    if (ov) s = 16'hFFFF;
`endif
    return {ov, s};
  endfunction

  // mode: 0 back-to-back, 1 two-cycle gaps, 2 random stalls
  task automatic run(input int nreq, input int mode,
                     input int hold);
    int n;
    int idx = 0;
    int cyc = 0;
    bit acc_now;
    logic [16:0] exp;
    n   = (nreq > MAX_OPS) ? MAX_OPS : nreq;
    exp = model(n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_ops = CW'(nreq);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (idx < n && cyc < 400) begin
      case (mode)
        1:       bus.in_valid = (cyc % 3 == 0);
        2:       bus.in_valid = ($urandom_range(0, 2) != 0);
        default: bus.in_valid = 1'b1;
      endcase
      bus.in_data = bus.in_valid ? ops[idx]
                                 : 16'($urandom);
      acc_now = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc_now) idx++;
      if (idx < n)
        check("early_valid", 32'(bus.out_valid), 32'd0);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("accept_count", idx, n);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    check("out_sum", 32'(bus.out_sum), 32'(exp[15:0]));
    check("out_ovf", 32'(bus.out_ovf), 32'(exp[16]));
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      bus.n_ops = CW'($urandom_range(0, 16));
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.out_sum),
            32'(exp[15:0]));
      check("hold_ovf", 32'(bus.out_ovf), 32'(exp[16]));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("sum_kept", 32'(bus.out_sum), 32'(exp[15:0]));
    check("ovf_kept", 32'(bus.out_ovf), 32'(exp[16]));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.n_ops     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_sum", 32'(bus.out_sum), 32'd0);
    check("rst_ovf", 32'(bus.out_ovf), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    ops = '{16'h0001, 16'h0002, 16'h0003};
    run(3, 0, 0);

    ops = '{16'hFFFF, 16'h0002};
    run(2, 0, 0);

    ops = '{16'hAAAA, 16'h5555, 16'h0000, 16'h0001};
    run(4, 1, 0);

    ops = {};
    run(0, 0, 5);

    // n_ops above MAX_OPS clamps to MAX_OPS
    ops = {};
    for (int i = 0; i < MAX_OPS; i++)
      ops.push_back(16'(i * 16'h0101 + 1));
    run(31, 0, 0);

    // Abort mid-accumulation with an async reset
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_ops = CW'(3);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7777;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd0);
    check("arst_sum", 32'(bus.out_sum), 32'd0);
    check("arst_ovf", 32'(bus.out_ovf), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ops = '{16'h1234};
    run(1, 0, 0);

    for (int r = 0; r < 20; r++) begin
      int n;
      n   = $urandom_range(1, MAX_OPS);
      ops = {};
      for (int i = 0; i < n; i++)
        ops.push_back(16'($urandom));
      run(n, 2, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acumulador_cla_16.md
# acumulador_cla_16

Sequential accumulator that sums a programmed number of unsigned N-bit operands, one per cycle, through an internal `CLA_16bits` instance (`Cin` tied to 0). It sits directly downstream of the operand source and upstream of result consumers. It turns the combinational carry-lookahead adder into a handshaked, registered datapath stage. It reports the final sum plus a sticky unsigned-overflow flag.

## Interface

Parameters:
- `N`, 16, operand and sum width. Only 16 is supported because the datapath is `CLA_16bits`.
- `MAX_OPS`, 16, maximum operands per accumulation.
- `CW`, `$clog2(MAX_OPS+1)`, width of the operand count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a new accumulation. Sampled in IDLE only.
- `n_ops`  in  CW  operand count, sampled with `start`. Legal range is 0..MAX_OPS.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block accepts an operand this cycle.
- `in_data`  in  N  unsigned operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  N  accumulated sum.
- `out_ovf`  out  1  sticky carry-out, set if any addition carried out of bit N-1.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, ACC, DONE.
- Reset is asynchronous on `rst_n` low:
  - state goes to IDLE.
  - acc = 0, ovf = 0, remaining = 0.
  - `in_ready` = 0, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `busy` = 0.
- IDLE:
  - `start`=1 with `n_ops`>0: clear acc and ovf, set remaining = `n_ops`, go to ACC.
  - `start`=1 with `n_ops`=0: clear acc and ovf, go to DONE. The result is 0 with ovf 0.
  - `n_ops`>MAX_OPS: clamp to MAX_OPS.
- ACC:
  - `in_ready`=1.
  - On accept (`in_valid`&&`in_ready`): acc <= CLA sum of acc + `in_data`, ovf <= ovf | CLA carry-out, remaining decrements.
  - Accept with remaining==1: go to DONE.
  - No accept: hold all state.
- DONE:
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`/`out_ovf` reflect the registered acc/ovf and stay stable until the result is taken.
  - `out_ready`=1: go to IDLE. `out_sum`/`out_ovf` keep their last value. `out_valid` drops the next cycle.
- `start` outside IDLE is ignored. It is not queued.
- Arithmetic is unsigned and modulo 2^N unless the saturation option below is compiled in. ovf is sticky for the whole accumulation.
- `rst_n` asserted mid-accumulation aborts it. No partial result is presented.

## Timing

- Throughput is one operand per cycle while in ACC.
- Latency: `out_valid` rises on the clock edge that accepts the last operand, so the result is visible the cycle after the last handshake.
- `n_ops`=0: `out_valid` is high the cycle after `start`.
- All outputs are registered or decoded from the state register only. There is no combinational path from `in_valid`, `in_data` or `out_ready` to any output.
- The minimum start-to-start interval is n_ops + 2 cycles, with `out_ready` held high.
- The CLA sits in a single-cycle path: acc register → `CLA_16bits` → acc register.

## Configuration

- Macro: `ACUM_SATURATE_EN`.
- Defined: when an addition carries out, acc loads 16'hFFFF and stays 16'hFFFF for the remaining operands. ovf is set as usual.
- Undefined: acc wraps modulo 2^16. ovf still records the carry.
- Handshake, latency and FSM behaviour are identical in both builds.

## Test plan

- `start`, `n_ops`=3, operands 16'h0001, 16'h0002, 16'h0003 back-to-back → `out_valid` on the cycle after the 3rd accept, `out_sum`=16'h0006, `out_ovf`=0.
- `n_ops`=2, operands 16'hFFFF, 16'h0002 → `out_ovf`=1. `out_sum`=16'h0001 without `ACUM_SATURATE_EN`, 16'hFFFF with it.
- `n_ops`=4, operands 16'hAAAA, 16'h5555, 16'h0000, 16'h0001 with `in_valid` gaps of 2 cycles → `out_sum`=16'h0000, `out_ovf`=1 (wrap build). No accepts occur during gaps.
- `n_ops`=0 → `out_valid`=1 the next cycle, `out_sum`=0, `out_ovf`=0. With `out_ready` held low for 5 cycles, the outputs stay stable and `start` pulses are ignored.
- Assert `rst_n`=0 asynchronously after 1 of 3 operands, then release and run `n_ops`=1 with 16'h1234 → all outputs 0 during reset, then `out_sum`=16'h1234 with no residue from before.
- 20 random runs (random `n_ops` 1..16, random operands, random `in_valid`/`out_ready` stalls) → `{out_ovf,out_sum}` matches the reference model.
